// File: rtl/adder_arbiter.sv
// Shares one external combinational adder among N_REQ valid/ready requesters; IDLE -> EXEC -> RESP per operation.
// Build option: define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module adder_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // req_valid may drop before acceptance; rsp_* are held stable while rsp_valid && !rsp_ready.
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    input  logic [N_REQ-1:0]         req_sub,
    output logic [WIDTH-1:0]         add_i_1,
    output logic [WIDTH-1:0]         add_i_2,
    output logic                     add_invert,
    input  logic [WIDTH-1:0]         add_o,
    input  logic                     add_overflow,
    input  logic                     add_zero,
    input  logic                     add_exception,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_overflow,
    output logic                     rsp_zero,
    output logic                     rsp_exception,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic              grant_any;
    logic [ID_W-1:0]   grant_idx;
    logic [WIDTH-1:0]  op_a_q, op_b_q;
    logic [WIDTH-1:0]  op_a_d, op_b_d;
    logic              op_sub_q, op_sub_d;
    logic [ID_W-1:0]   op_id_q;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic              rsp_overflow_q, rsp_zero_q, rsp_exception_q;

`ifdef ADDER_ARB_FIXED_PRIO_EN
    // Scanning downward leaves the lowest valid index as the winner.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] last_q;

    // Search starts just after the most recent winner and wraps around.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last_q) + i) % N_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= ID_W'(N_REQ - 1);
        end else if (state_q == IDLE && grant_any) begin
            last_q <= grant_idx;
        end
    end
`endif

    assign op_a_d   = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    assign op_b_d   = req_b[int'(grant_idx)*WIDTH +: WIDTH];
    assign op_sub_d = req_sub[grant_idx];

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !rst && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            op_a_q          <= '0;
            op_b_q          <= '0;
            op_sub_q        <= 1'b0;
            op_id_q         <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_data_q      <= '0;
            rsp_overflow_q  <= 1'b0;
            rsp_zero_q      <= 1'b0;
            rsp_exception_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        op_a_q   <= op_a_d;
                        op_b_q   <= op_b_d;
                        op_sub_q <= op_sub_d;
                        op_id_q  <= grant_idx;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    // Adder flags are passed through untouched.
                    rsp_data_q      <= add_o;
                    rsp_overflow_q  <= add_overflow;
                    rsp_zero_q      <= add_zero;
                    rsp_exception_q <= add_exception;
                    rsp_id_q        <= op_id_q;
                    rsp_valid_q     <= 1'b1;
                    state_q         <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign add_i_1       = op_a_q;
    assign add_i_2       = op_b_q;
    assign add_invert    = op_sub_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_data      = rsp_data_q;
    assign rsp_overflow  = rsp_overflow_q;
    assign rsp_zero      = rsp_zero_q;
    assign rsp_exception = rsp_exception_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: behavioural adder stub, arithmetic reference model and an expected-response queue.
module tb_adder_arbiter;
  localparam int WIDTH = 32;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int SB_W  = ID_W + 3 + WIDTH;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_sub;
  logic [WIDTH-1:0]       add_i_1, add_i_2, add_o;
  logic                   add_invert, add_overflow, add_zero, add_exception;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b0;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_data;
  logic                   rsp_overflow, rsp_zero, rsp_exception;
  logic [1:0]             dbg_state;

  logic [WIDTH-1:0] a_m [N_REQ];
  logic [WIDTH-1:0] b_m [N_REQ];
  logic             sub_m [N_REQ];

  logic [SB_W-1:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int rr_last = N_REQ - 1;

  // clock / reset
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_a[k*WIDTH +: WIDTH] = a_m[k];
      req_b[k*WIDTH +: WIDTH] = b_m[k];
      req_sub[k]              = sub_m[k];
    end
  end

  // shared adder stub: i_1 + (invert ? ~i_2 + 1 : i_2)
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_full;
  assign b_eff         = add_invert ? ~add_i_2 : add_i_2;
  assign add_full      = {1'b0, add_i_1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, add_invert};
  assign add_o         = add_full[WIDTH-1:0];
  assign add_exception = add_full[WIDTH];
  assign add_zero      = (add_full[WIDTH-1:0] == '0);
  assign add_overflow  = (add_i_1[WIDTH-1] == b_eff[WIDTH-1]) && (add_full[WIDTH-1] != add_i_1[WIDTH-1]);

  adder_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .add_i_1(add_i_1), .add_i_2(add_i_2), .add_invert(add_invert),
    .add_o(add_o), .add_overflow(add_overflow), .add_zero(add_zero), .add_exception(add_exception),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_exception(rsp_exception),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: signed arithmetic on wide integers, flags from the result
  function automatic logic [SB_W-1:0] ref_result(input int id, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b, input logic sub);
    longint sa, sb, r;
    logic [WIDTH-1:0] data;
    logic ov, zr, ex;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sub ? (sa - sb) : (sa + sb);
    ov = (r > (2**(WIDTH-1)) - 1) || (r < -(2**(WIDTH-1)));
    data = WIDTH'(r);
    zr = (data == 0);
    if (sub) ex = (a >= b);
    else     ex = ((longint'(a) + longint'(b)) >= (longint'(1) << WIDTH));
    return {ID_W'(id), ex, zr, ov, data};
  endfunction

  function automatic int pick(input logic [N_REQ-1:0] mask);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) if (mask[i]) return i;
`else
    for (int i = 1; i <= N_REQ; i++) if (mask[(rr_last + i) % N_REQ]) return (rr_last + i) % N_REQ;
`endif
    return 0;
  endfunction

  task automatic set_req(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sub);
    a_m[k] = a; b_m[k] = b; sub_m[k] = sub;
  endtask

  task automatic check_rsp(input string tag, input logic [SB_W-1:0] e);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_ready0"}, req_ready, 0);
    check({tag, "_data"}, rsp_data, e[WIDTH-1:0]);
    check({tag, "_ov"}, rsp_overflow, e[WIDTH]);
    check({tag, "_zero"}, rsp_zero, e[WIDTH+1]);
    check({tag, "_exc"}, rsp_exception, e[WIDTH+2]);
    check({tag, "_id"}, rsp_id, e[SB_W-1 -: ID_W]);
  endtask

  // driver: called at a negedge in IDLE; returns one negedge after the response handshake
  task automatic transact(input logic [N_REQ-1:0] mask, input int stall);
    int g;
    logic [WIDTH-1:0] a_s, b_s;
    logic sub_s;
    logic [SB_W-1:0] e;
    req_valid = mask;
    #1;
    g = pick(mask);
    check("accept_ready", req_ready, N_REQ'(1) << g);
    a_s = a_m[g]; b_s = b_m[g]; sub_s = sub_m[g];
    exp_q.push_back(ref_result(g, a_s, b_s, sub_s));
    rr_last = g;
    @(negedge clk);
    req_valid = '1;
    a_m[g] = $urandom; b_m[g] = $urandom;
    #1;
    check("exec_ready0", req_ready, 0);
    check("exec_rsp_valid0", rsp_valid, 0);
    check("exec_i_1", add_i_1, a_s);
    check("exec_i_2", add_i_2, b_s);
    check("exec_invert", add_invert, sub_s);
    @(negedge clk);
    e = exp_q.pop_front();
    for (int s = 0; s <= stall; s++) begin
      rsp_ready = (s == stall);
      #1;
      check_rsp("rsp", e);
      if (s < stall) @(negedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = '0;
    #1;
    check("post_hs_valid0", rsp_valid, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_last = N_REQ - 1;
  endtask

  initial begin
    for (int k = 0; k < N_REQ; k++) set_req(k, '0, '0, 1'b0);

    // reset state, with every requester valid
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_flags", {rsp_overflow, rsp_zero, rsp_exception}, 0);
    check("rst_add_ops", {add_i_1, add_i_2, add_invert}, 0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);

    // single request from requester 2: 15 - 39 = -24
    set_req(2, 32'd15, 32'd39, 1'b1);
    transact(4'b0100, 0);

    // overflow then zero
    set_req(1, 32'h7FFF_FFFF, 32'd1, 1'b0);
    transact(4'b0010, 0);
    set_req(3, 32'd272, 32'd272, 1'b1);
    transact(4'b1000, 0);

    // golden sequence
    set_req(0, 32'd210, 32'd230, 1'b1);
    transact(4'b0001, 0);
    set_req(2, 32'd0, 32'd1000, 1'b1);
    transact(4'b0100, 0);
    set_req(1, 32'd32, 32'd64, 1'b0);
    transact(4'b0010, 0);

    // backpressure for 10 cycles, then next grant straight after the handshake
    set_req(0, 32'd5, 32'd7, 1'b0);
    set_req(3, 32'd100, 32'd1, 1'b1);
    transact(4'b1001, 10);
    transact(4'b1001, 0);

    // contention from reset: one accept every 3 cycles with rsp_ready tied high
    pulse_reset();
    for (int k = 0; k < N_REQ; k++) set_req(k, WIDTH'(k * 10), WIDTH'(k), 1'b0);
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 15; c++) begin
      int id;
`ifdef ADDER_ARB_FIXED_PRIO_EN
      id = 0;
`else
      id = (c / 3) % N_REQ;
`endif
      #1;
      if (c % 3 == 0) check("cont_ready", req_ready, N_REQ'(1) << id);
      else            check("cont_ready0", req_ready, 0);
      if (c % 3 == 2) begin
        check("cont_rsp_valid", rsp_valid, 1);
        check("cont_rsp_id", rsp_id, id);
        check("cont_rsp_data", rsp_data, WIDTH'(id * 11));
      end else begin
        check("cont_rsp_valid0", rsp_valid, 0);
      end
      if (c == 14) req_valid = '0;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    rr_last = 0;
`else
    rr_last = 0;
`endif

    // reset one cycle after accept: operation discarded, lowest valid index wins afterwards
    set_req(2, 32'd1, 32'd2, 1'b0);
    req_valid = 4'b0100;
    #1;
    check("rstx_accept", req_ready, 4'b0100);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    #1;
    check("rstx_i_1", add_i_1, 0);
    check("rstx_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    rr_last = N_REQ - 1;
    #1;
    check("rstx_rsp_valid_after", rsp_valid, 0);
    set_req(0, 32'd9, 32'd4, 1'b1);
    set_req(3, 32'd9, 32'd4, 1'b0);
    transact(4'b1001, 0);

    // randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < N_REQ; k++) begin
        case ($urandom_range(0, 4))
          0:       set_req(k, 32'h7FFF_FFFF, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
          1:       set_req(k, 32'h8000_0000, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
          2:       begin a_m[k] = $urandom; b_m[k] = a_m[k]; sub_m[k] = 1'b1; end
          default: set_req(k, $urandom, $urandom, $urandom_range(0, 1) == 1);
        endcase
      end
      transact(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), $urandom_range(0, 3));
    end

    // final report
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one combinational `adder` instance (add/subtract via `invert_i_2`) among `N_REQ` requesters. Each requester presents operands and an add/sub select over a valid/ready handshake. The block grants one request at a time, drives the shared adder from registered operands, and returns the result, flags and requester ID over a single response channel with backpressure. It sits between the ALU-side clients and the adder datapath; the adder itself is instantiated outside and wired to the `add_*` ports.

## Interface
- `WIDTH`, 32, operand/result width; must match the shared adder.
- `N_REQ`, 4, number of requesters, 2..16.
- `ID_W`, $clog2(N_REQ), width of `rsp_id`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  N_REQ*WIDTH  operand 1, requester k at bits [k*WIDTH +: WIDTH].
- `req_b`  in  N_REQ*WIDTH  operand 2, same packing.
- `req_sub`  in  N_REQ  1 = a-b, 0 = a+b.
- `add_i_1`, `add_i_2`  out  WIDTH  to adder `i_1`/`i_2`.
- `add_invert`  out  1  to adder `invert_i_2`.
- `add_o`  in  WIDTH  from adder `o`.
- `add_overflow`, `add_zero`, `add_exception`  in  1  adder flags.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_id`  out  ID_W  index of the served requester.
- `rsp_data`  out  WIDTH  result.
- `rsp_overflow`, `rsp_zero`, `rsp_exception`  out  1  captured flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is set, the arbiter picks grant index g.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - Latch `req_a[g]`, `req_b[g]`, `req_sub[g]` and g into the op registers.
  - Transition to EXEC.
  - If no `req_valid` is set, stay in IDLE.
- **EXEC**
  - `add_i_1`, `add_i_2` and `add_invert` are driven from the op registers. They are registered signals, stable for the whole state.
  - At the end of the cycle, capture `add_o` and the three flags into the response registers.
  - Transition to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - All `rsp_*` outputs are held stable until `rsp_ready`=1.
  - On the handshake, return to IDLE.
- `req_ready` is 0 in EXEC and RESP.
- **Round-robin arbitration**
  - Pointer `last` holds the most recently granted index.
  - Search order is last+1, last+2, … mod N_REQ. The first valid requester wins.
  - `last` updates to g on each grant.
- Arithmetic is two's complement, modulo 2^WIDTH. Flags are the adder's own; the arbiter never recomputes them.
- Requesters may change or drop `req_valid` at any time before acceptance. There is no obligation to hold.

## Timing
- **Reset values** (asynchronous, effective immediately on `rst`=1):
  - state = IDLE; `last` = N_REQ-1, so requester 0 wins first.
  - Op registers = 0, so `add_i_1` = `add_i_2` = 0 and `add_invert` = 0.
  - `req_ready` = 0 while `rst` is asserted.
  - `rsp_valid` = 0; `rsp_id` = `rsp_data` = 0; all `rsp_*` flags = 0.
- **Latency:** acceptance in cycle T (IDLE) → adder evaluated in T+1 (EXEC) → `rsp_valid` rises at T+2.
- **Throughput:** minimum 3 cycles per operation. With `rsp_ready` tied high, accepts occur at T, T+3, T+6, …
- **Backpressure:** with `rsp_ready` held low, the block stays in RESP indefinitely and accepts no new requests.
- **Reset mid-operation** (EXEC or RESP): the in-flight operation is discarded with no response. After reset, the first grant goes to the lowest valid index.
- **Single requester:** a lone valid requester is always granted, regardless of `last`.

## Configuration
- `ADDER_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority. The lowest-indexed valid requester always wins; the `last` pointer is not implemented.
  - Undefined (default): round-robin as described above.
  - All other behaviour and timing are identical in both builds.

## Test plan
- Single request: requester 2 sends a=15, b=39, sub=1 → `req_ready[2]` in the accept cycle; 2 cycles later `rsp_valid`=1 with `rsp_data`=-24, `rsp_id`=2, `rsp_overflow`=0.
- Contention: all four requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0, one response every 3 cycles. Under `ADDER_ARB_FIXED_PRIO_EN` the sequence is 0,0,0,….
- Backpressure: response pending with `rsp_ready`=0 for 10 cycles → `rsp_*` stable, `req_ready`=0; release → handshake, then the next grant the following cycle.
- Overflow/zero: a=0x7FFFFFFF, b=1, sub=0 → `rsp_data`=0x80000000, `rsp_overflow`=1. Then a=272, b=272, sub=1 → `rsp_data`=0, `rsp_zero`=1.
- Reset in EXEC: assert `rst` one cycle after accept → `rsp_valid` never rises. After release, requester 0 (valid) is granted first.
- Sequence: a=210, b=230, sub=1 → -20; a=0, b=1000, sub=1 → -1000; a=32, b=64, sub=0 → 96; each result and `rsp_id` matches the golden value.
